hex_to_n_digit_ca_mux: RTL

HEX_TO_N_DIGIT_CA_MUX -- requirements
Module: hex_to_n_digit_ca_mux

---
 rtl/hex_to_n_digit_ca_mux.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hex_to_n_digit_ca_mux.sv
// Multiplexed common-anode hex display driver with shadow/active
// frame buffering, brightness gating and leading-zero blanking.
module hex_to_n_digit_ca_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hex_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [6:0]            Segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_start
);

  localparam int SUB_LEN = SCAN_DIV / 16;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int PW = $clog2(SUB_LEN);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic [3:0]          sub_q, sub_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shd_hex_q, shd_hex_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] act_hex_q, act_hex_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fs_q, fs_d;

  logic slot_end, frame_end, ph_end;
  logic [3:0] nib;
  logic lz_sel, dpa, run, blank, gate;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan timing: slot counter, sub-phase tracker and digit index
  always_comb begin
    slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
    ph_end    = (ph_q == PW'(SUB_LEN - 1));
    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    ph_d  = (slot_end || ph_end) ? '0 : ph_q + PW'(1);
    sub_d = sub_q;
    if (slot_end)
      sub_d = 4'd0;
    else if (ph_end)
      sub_d = sub_q + 4'd1;
    idx_d = idx_q;
    if (slot_end)
      idx_d = frame_end ? '0 : idx_q + IW'(1);
  end

  // Old shadow moves to active before a coincident load overwrites it
  always_comb begin
    shd_hex_d = shd_hex_q;
    shd_dp_d  = shd_dp_q;
    pend_d    = pend_q;
    act_hex_d = act_hex_q;
    act_dp_d  = act_dp_q;
    if (frame_end && pend_q) begin
      act_hex_d = shd_hex_q;
      act_dp_d  = shd_dp_q;
      pend_d    = 1'b0;
    end
    if (load) begin
      shd_hex_d = hex_in;
      shd_dp_d  = dp_in;
      pend_d    = 1'b1;
    end
  end

  always_comb begin
    nib    = 4'd0;
    lz_sel = 1'b0;
    dpa    = 1'b0;
    run    = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run = run & (act_hex_q[4*k +: 4] == 4'd0);
      if (idx_q == IW'(k)) begin
        nib    = act_hex_q[4*k +: 4];
        lz_sel = run;
        dpa    = act_dp_q[k];
      end
    end
    blank = blank_lz && (idx_q != '0) && lz_sel;
    gate  = (cnt_q != '0) && (sub_q <= bright);
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    fs_d  = (cnt_q == '0) && (idx_q == '0);
    if (cnt_q != '0) begin
      seg_d = blank ? 7'h7F : dec7(nib);
      dp_d  = ~dpa;
    end
    for (int k = 0; k < DIGITS; k++)
      sel_d[k] = ~(gate && (idx_q == IW'(k)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      ph_q      <= '0;
      sub_q     <= '0;
      idx_q     <= '0;
      shd_hex_q <= '0;
      shd_dp_q  <= '0;
      pend_q    <= 1'b0;
      act_hex_q <= '0;
      act_dp_q  <= '0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      sel_q     <= '1;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      sub_q     <= sub_d;
      idx_q     <= idx_d;
      shd_hex_q <= shd_hex_d;
      shd_dp_q  <= shd_dp_d;
      pend_q    <= pend_d;
      act_hex_q <= act_hex_d;
      act_dp_q  <= act_dp_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      sel_q     <= sel_d;
      fs_q      <= fs_d;
    end
  end

  assign Segments    = seg_q;
  assign dp          = dp_q;
  assign sel         = sel_q;
  assign frame_start = fs_q;

endmodule
